// File: rtl/fir_addr_seq.sv
// fir_addr_seq: control FSM and RAM address generator for the FIR engine.
// Sequences zero fill, circular sample write, tap sweep and the result handshake.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for ap_start after reset
//   INIT    | zero-fill data RAM words 0..N-1
//   WAIT_IN | ready for one stream sample, accumulator held clear
//   WRITE   | write accepted sample at wr_ptr
//   MAC     | sweep tap k and data (wr_ptr-k) mod N, k = 0..N-1
//   DRAIN   | wait out RAM read latency before the result is complete
//   OUT     | result_valid held until result_ready
//   DONE    | all L outputs produced; waiting for ap_start
module fir_addr_seq #(
    parameter int pADDR_WIDTH = 12,
    parameter int pMAX_TAPS   = 32,
    parameter int pTAP_W      = 6,
    parameter int pCNT_WIDTH  = 10,
    parameter int pRD_LAT     = 1,
    parameter int pSTRIDE     = 4
) (
    input  logic                   i_axis_clk,
    input  logic                   i_axis_rst_n,
    input  logic                   i_ap_start,
    input  logic [pTAP_W-1:0]      i_tap_num,
    input  logic [pCNT_WIDTH-1:0]  i_data_len,
    input  logic                   i_ss_tvalid,
    output logic                   o_ss_tready,
    output logic                   o_data_we,
    output logic                   o_data_zero,
    output logic [pADDR_WIDTH-1:0] o_data_waddr,
    output logic [pADDR_WIDTH-1:0] o_tap_raddr,
    output logic [pADDR_WIDTH-1:0] o_data_raddr,
    output logic                   o_mac_clr,
    output logic                   o_mac_en,
    output logic                   o_mac_last,
    output logic                   o_result_valid,
    input  logic                   i_result_ready,
    output logic [pCNT_WIDTH-1:0]  o_sample_cnt,
    output logic                   o_busy,
    output logic                   o_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_WAIT_IN, S_WRITE, S_MAC, S_DRAIN, S_OUT, S_DONE
    } state_t;

    localparam logic [pTAP_W-1:0]     lpTAP_ONE = 1;
    localparam logic [pCNT_WIDTH-1:0] lpCNT_ONE = 1;

    state_t                  r_state, w_state_nx;
    logic [pTAP_W-1:0]       r_cnt, w_cnt_nx;
    logic [pTAP_W-1:0]       r_wr_ptr, w_wr_ptr_nx;
    logic [pTAP_W-1:0]       r_n, w_n_nx, w_n_clamp;
    logic [pCNT_WIDTH-1:0]   r_len, w_len_nx;
    logic [pCNT_WIDTH-1:0]   r_sample_cnt, w_sample_cnt_nx;

    logic                    r_ss_tready, r_data_we, r_data_zero, r_mac_clr;
    logic                    r_result_valid, r_busy, r_done;
    logic [pADDR_WIDTH-1:0]  r_data_waddr, r_tap_raddr, r_data_raddr;
    logic [pRD_LAT:0]        r_en_pipe, r_last_pipe;

    logic                    w_tready_nx, w_we_nx, w_zero_nx, w_clr_nx;
    logic                    w_valid_nx, w_busy_nx, w_done_nx;
    logic                    w_stb_nx, w_stb_last_nx;
    logic [pADDR_WIDTH-1:0]  w_waddr_nx, w_traddr_nx, w_draddr_nx;
    logic [pTAP_W-1:0]       w_circ_nx;

    function automatic logic [pADDR_WIDTH-1:0] word_addr(input logic [pTAP_W-1:0] idx);
        return pADDR_WIDTH'(idx) * pADDR_WIDTH'(pSTRIDE);
    endfunction

    always_comb begin
        if (i_tap_num == '0)
            w_n_clamp = lpTAP_ONE;
        else if (int'(i_tap_num) > pMAX_TAPS)
            w_n_clamp = pTAP_W'(pMAX_TAPS);
        else
            w_n_clamp = i_tap_num;
    end

    always_ff @(posedge i_axis_clk or negedge i_axis_rst_n) begin
        if (!i_axis_rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_wr_ptr     <= '0;
            r_n          <= lpTAP_ONE;
            r_len        <= '0;
            r_sample_cnt <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_cnt        <= w_cnt_nx;
            r_wr_ptr     <= w_wr_ptr_nx;
            r_n          <= w_n_nx;
            r_len        <= w_len_nx;
            r_sample_cnt <= w_sample_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx      = r_state;
        w_cnt_nx        = r_cnt;
        w_wr_ptr_nx     = r_wr_ptr;
        w_n_nx          = r_n;
        w_len_nx        = r_len;
        w_sample_cnt_nx = r_sample_cnt;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_ap_start) begin
                    w_state_nx      = S_INIT;
                    w_cnt_nx        = '0;
                    w_wr_ptr_nx     = '0;
                    w_n_nx          = w_n_clamp;
                    w_len_nx        = i_data_len;
                    w_sample_cnt_nx = '0;
                end
            end
            S_INIT: begin
                if (r_cnt == r_n - lpTAP_ONE) begin
                    w_cnt_nx   = '0;
                    w_state_nx = (r_len == '0) ? S_DONE : S_WAIT_IN;
                end else begin
                    w_cnt_nx = r_cnt + lpTAP_ONE;
                end
            end
            S_WAIT_IN: begin
                if (i_ss_tvalid)
                    w_state_nx = S_WRITE;
            end
            S_WRITE: begin
                w_state_nx = S_MAC;
                w_cnt_nx   = '0;
            end
            S_MAC: begin
                if (r_cnt == r_n - lpTAP_ONE) begin
                    w_cnt_nx    = '0;
                    w_wr_ptr_nx = (r_wr_ptr == r_n - lpTAP_ONE) ? '0 : r_wr_ptr + lpTAP_ONE;
                    w_state_nx  = (pRD_LAT == 0) ? S_OUT : S_DRAIN;
                end else begin
                    w_cnt_nx = r_cnt + lpTAP_ONE;
                end
            end
            S_DRAIN: begin
                if (int'(r_cnt) >= pRD_LAT - 1) begin
                    w_cnt_nx   = '0;
                    w_state_nx = S_OUT;
                end else begin
                    w_cnt_nx = r_cnt + lpTAP_ONE;
                end
            end
            S_OUT: begin
                if (i_result_ready) begin
                    w_sample_cnt_nx = r_sample_cnt + lpCNT_ONE;
                    w_state_nx = (r_sample_cnt + lpCNT_ONE == r_len) ? S_DONE : S_WAIT_IN;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every port comes straight from a flop.
    always_comb begin
        w_tready_nx   = (w_state_nx == S_WAIT_IN);
        w_clr_nx      = (w_state_nx == S_WAIT_IN);
        w_we_nx       = (w_state_nx == S_INIT) || (w_state_nx == S_WRITE);
        w_zero_nx     = (w_state_nx == S_INIT);
        w_valid_nx    = (w_state_nx == S_OUT);
        w_done_nx     = (w_state_nx == S_DONE);
        w_busy_nx     = (w_state_nx != S_IDLE) && (w_state_nx != S_DONE);
        w_stb_nx      = (w_state_nx == S_MAC);
        w_stb_last_nx = w_stb_nx && (w_cnt_nx == w_n_nx - lpTAP_ONE);
        w_circ_nx     = (w_cnt_nx <= w_wr_ptr_nx) ? w_wr_ptr_nx - w_cnt_nx
                                                  : w_n_nx - w_cnt_nx + w_wr_ptr_nx;
        w_waddr_nx    = '0;
        if (w_state_nx == S_INIT)
            w_waddr_nx = word_addr(w_cnt_nx);
        else if (w_state_nx == S_WRITE)
            w_waddr_nx = word_addr(w_wr_ptr_nx);
        w_traddr_nx   = w_stb_nx ? word_addr(w_cnt_nx) : '0;
        w_draddr_nx   = w_stb_nx ? word_addr(w_circ_nx) : '0;
    end

    always_ff @(posedge i_axis_clk or negedge i_axis_rst_n) begin
        if (!i_axis_rst_n) begin
            r_ss_tready    <= 1'b0;
            r_mac_clr      <= 1'b0;
            r_data_we      <= 1'b0;
            r_data_zero    <= 1'b0;
            r_result_valid <= 1'b0;
            r_done         <= 1'b0;
            r_busy         <= 1'b0;
            r_data_waddr   <= '0;
            r_tap_raddr    <= '0;
            r_data_raddr   <= '0;
            r_en_pipe      <= '0;
            r_last_pipe    <= '0;
        end else begin
            r_ss_tready    <= w_tready_nx;
            r_mac_clr      <= w_clr_nx;
            r_data_we      <= w_we_nx;
            r_data_zero    <= w_zero_nx;
            r_result_valid <= w_valid_nx;
            r_done         <= w_done_nx;
            r_busy         <= w_busy_nx;
            r_data_waddr   <= w_waddr_nx;
            r_tap_raddr    <= w_traddr_nx;
            r_data_raddr   <= w_draddr_nx;
            r_en_pipe[0]   <= w_stb_nx;
            r_last_pipe[0] <= w_stb_last_nx;
            for (int i = 1; i <= pRD_LAT; i++) begin
                r_en_pipe[i]   <= r_en_pipe[i-1];
                r_last_pipe[i] <= r_last_pipe[i-1];
            end
        end
    end

    assign o_ss_tready    = r_ss_tready;
    assign o_mac_clr      = r_mac_clr;
    assign o_data_we      = r_data_we;
    assign o_data_zero    = r_data_zero;
    assign o_data_waddr   = r_data_waddr;
    assign o_tap_raddr    = r_tap_raddr;
    assign o_data_raddr   = r_data_raddr;
    assign o_mac_en       = r_en_pipe[pRD_LAT];
    assign o_mac_last     = r_last_pipe[pRD_LAT];
    assign o_result_valid = r_result_valid;
    assign o_sample_cnt   = r_sample_cnt;
    assign o_busy         = r_busy;
    assign o_done         = r_done;

endmodule

// File: tb/tb_fir_addr_seq.sv
// Directed bench for fir_addr_seq: one instance at read latency 1, one at latency 2.
// Expected addresses and cycle offsets are hand-derived from the sequencing rules.
module tb_fir_addr_seq;
    localparam int AW = 12;
    localparam int TW = 6;
    localparam int CW = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ap_start = 1'b0;
    logic ap_start2 = 1'b0;
    logic [TW-1:0] tap_num = '0;
    logic [CW-1:0] data_len = '0;
    logic tvalid = 1'b0;
    logic rready = 1'b0;

    logic d1_tready, d1_we, d1_zero, d1_clr, d1_en, d1_last, d1_valid, d1_busy, d1_done;
    logic [AW-1:0] d1_waddr, d1_traddr, d1_draddr;
    logic [CW-1:0] d1_scnt;
    logic d2_tready, d2_we, d2_zero, d2_clr, d2_en, d2_last, d2_valid, d2_busy, d2_done;
    logic [AW-1:0] d2_waddr, d2_traddr, d2_draddr;
    logic [CW-1:0] d2_scnt;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int exp_n = 1;
    int sweep_left = 0;
    logic prev_valid = 1'b0;

    logic [AW-1:0] init_q[$], wr_q[$], tap_q[$], dra_q[$];
    int wr_cyc_q[$], en_cyc_q[$], vr_cyc_q[$];
    logic last_q[$];

    int wcyc, vcyc, nticks;
    int en2_q[$];
    logic last2_q[$];
    logic pv2;

    fir_addr_seq #(.pRD_LAT(1)) u_dut (
        .i_axis_clk(clk), .i_axis_rst_n(rst_n), .i_ap_start(ap_start),
        .i_tap_num(tap_num), .i_data_len(data_len), .i_ss_tvalid(tvalid),
        .o_ss_tready(d1_tready), .o_data_we(d1_we), .o_data_zero(d1_zero),
        .o_data_waddr(d1_waddr), .o_tap_raddr(d1_traddr), .o_data_raddr(d1_draddr),
        .o_mac_clr(d1_clr), .o_mac_en(d1_en), .o_mac_last(d1_last),
        .o_result_valid(d1_valid), .i_result_ready(rready), .o_sample_cnt(d1_scnt),
        .o_busy(d1_busy), .o_done(d1_done)
    );

    fir_addr_seq #(.pRD_LAT(2)) u_dut_lat2 (
        .i_axis_clk(clk), .i_axis_rst_n(rst_n), .i_ap_start(ap_start2),
        .i_tap_num(tap_num), .i_data_len(data_len), .i_ss_tvalid(tvalid),
        .o_ss_tready(d2_tready), .o_data_we(d2_we), .o_data_zero(d2_zero),
        .o_data_waddr(d2_waddr), .o_tap_raddr(d2_traddr), .o_data_raddr(d2_draddr),
        .o_mac_clr(d2_clr), .o_mac_en(d2_en), .o_mac_last(d2_last),
        .o_result_valid(d2_valid), .i_result_ready(rready), .o_sample_cnt(d2_scnt),
        .o_busy(d2_busy), .o_done(d2_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder for the latency-1 instance; MAC sweep is the N cycles after WRITE.
    always @(negedge clk) begin
        if (rst_n) begin
            if (d1_we && d1_zero) init_q.push_back(d1_waddr);
            if (d1_we && !d1_zero) begin
                wr_q.push_back(d1_waddr);
                wr_cyc_q.push_back(cyc);
                sweep_left = exp_n;
            end else if (sweep_left > 0) begin
                tap_q.push_back(d1_traddr);
                dra_q.push_back(d1_draddr);
                sweep_left--;
            end
            if (d1_en) begin
                en_cyc_q.push_back(cyc);
                last_q.push_back(d1_last);
            end
            if (d1_valid && !prev_valid) vr_cyc_q.push_back(cyc);
            prev_valid = d1_valid;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        init_q.delete(); wr_q.delete(); tap_q.delete(); dra_q.delete();
        wr_cyc_q.delete(); en_cyc_q.delete(); vr_cyc_q.delete(); last_q.delete();
        sweep_left = 0;
    endtask

    task automatic start1(input int n, input int l, input int expn);
        tap_num = TW'(n);
        data_len = CW'(l);
        exp_n = expn;
        clear_q();
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (!d1_done && n < budget) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(d1_done), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq(tag, {d1_tready, d1_we, d1_zero, d1_clr, d1_en, d1_last, d1_valid, d1_busy, d1_done,
                       d1_waddr, d1_traddr, d1_draddr != '0, d1_scnt != '0}, 32'd0);
    endtask

    initial begin
        tick(); tick();
        check_all_zero("reset_outputs");
        rst_n = 1'b1;
        tick();

        // N=11, L=3, free-flowing handshakes
        tvalid = 1'b1; rready = 1'b1;
        start1(11, 3, 11);
        wait_done(300, "n11_done");
        check_eq("n11_init_count", init_q.size(), 11);
        for (int j = 0; j < 11; j++)
            if (init_q.size() > j) check_eq($sformatf("n11_init_addr%0d", j), init_q[j], 32'(j * 4));
        check_eq("n11_wr_count", wr_q.size(), 3);
        if (wr_q.size() >= 2) begin
            check_eq("n11_wr0", wr_q[0], 32'h0);
            check_eq("n11_wr1", wr_q[1], 32'h4);
        end
        check_eq("n11_sweep_len", dra_q.size(), 33);
        if (dra_q.size() >= 22)
            for (int k = 0; k < 11; k++) begin
                check_eq($sformatf("n11_draddr_k%0d", k), dra_q[11 + k], 32'(((1 - k + 11) % 11) * 4));
                check_eq($sformatf("n11_traddr_k%0d", k), tap_q[11 + k], 32'(k * 4));
            end
        check_eq("n11_en_count", en_cyc_q.size(), 33);
        if (en_cyc_q.size() == 33 && wr_cyc_q.size() == 3 && vr_cyc_q.size() >= 1) begin
            check_eq("n11_first_en_lat", en_cyc_q[0], wr_cyc_q[0] + 2);
            check_eq("n11_en_contig", en_cyc_q[10], en_cyc_q[0] + 10);
            check_eq("n11_valid_after_last", vr_cyc_q[0], en_cyc_q[10] + 1);
            for (int i = 0; i < 33; i++)
                check_eq($sformatf("n11_last%0d", i), 32'(last_q[i]), 32'((i % 11) == 10));
        end
        check_eq("n11_sample_cnt", d1_scnt, 32'd3);
        check_eq("n11_busy_in_done", d1_busy, 32'd0);

        // N=4 over 6 samples: circular write wrap
        start1(4, 6, 4);
        wait_done(300, "n4_done");
        check_eq("n4_wr_count", wr_q.size(), 6);
        for (int i = 0; i < 6; i++)
            if (wr_q.size() > i) check_eq($sformatf("n4_wr%0d", i), wr_q[i], 32'((i % 4) * 4));

        // Latency-2 instance, N=3, L=1
        tap_num = 6'd3; data_len = 10'd1;
        ap_start2 = 1'b1; tick(); ap_start2 = 1'b0;
        wcyc = -1; vcyc = -1; pv2 = 1'b0; en2_q.delete(); last2_q.delete();
        for (int i = 0; i < 60 && !d2_done; i++) begin
            if (d2_we && !d2_zero) wcyc = cyc;
            if (d2_en) begin en2_q.push_back(cyc); last2_q.push_back(d2_last); end
            if (d2_valid && !pv2 && vcyc < 0) vcyc = cyc;
            pv2 = d2_valid;
            tick();
        end
        check_eq("lat2_done", d2_done, 32'd1);
        check_eq("lat2_en_count", en2_q.size(), 3);
        if (en2_q.size() == 3) begin
            check_eq("lat2_first_en", en2_q[0], wcyc + 3);
            check_eq("lat2_third_en", en2_q[2], wcyc + 5);
            check_eq("lat2_last_flags", {last2_q[0], last2_q[1], last2_q[2]}, 32'b001);
        end
        check_eq("lat2_valid_rise", vcyc, wcyc + 6);

        // Result backpressure
        rready = 1'b0;
        start1(2, 2, 2);
        nticks = 0;
        while (!d1_valid && nticks < 50) begin tick(); nticks++; end
        check_eq("bp_valid_seen", d1_valid, 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq($sformatf("bp_hold%0d", i), {d1_valid, d1_tready, d1_scnt}, {1'b1, 1'b0, 10'd0});
        end
        rready = 1'b1;
        tick();
        check_eq("bp_accept_cnt", d1_scnt, 32'd1);
        check_eq("bp_accept_valid", d1_valid, 32'd0);
        wait_done(100, "bp_done");
        check_eq("bp_final_cnt", d1_scnt, 32'd2);

        // tap_num=0 clamps to a single tap
        start1(0, 1, 1);
        wait_done(100, "t0_done");
        check_eq("t0_init_count", init_q.size(), 1);
        check_eq("t0_en_count", en_cyc_q.size(), 1);
        if (last_q.size() == 1) check_eq("t0_last", last_q[0], 32'd1);
        if (dra_q.size() == 1) check_eq("t0_addrs", {tap_q[0], dra_q[0]}, 32'd0);

        // tap_num=40 clamps to 32; L=0 goes straight to DONE after INIT
        start1(40, 0, 32);
        nticks = 0;
        while (!d1_done && nticks < 100) begin tick(); nticks++; end
        check_eq("t40_init_cycles", nticks, 32'd32);
        check_eq("t40_init_count", init_q.size(), 32);
        if (init_q.size() == 32) check_eq("t40_last_init_addr", init_q[31], 32'h7C);
        check_eq("l0_no_writes", wr_q.size(), 0);
        check_eq("l0_done", d1_done, 32'd1);

        // ap_start while busy is ignored
        tvalid = 1'b0;
        start1(4, 2, 4);
        for (int i = 0; i < 10; i++) tick();
        check_eq("busy_wait_in", {d1_busy, d1_tready}, 32'b11);
        tap_num = 6'd1; data_len = 10'd5;
        ap_start = 1'b1; tick(); ap_start = 1'b0;
        tvalid = 1'b1;
        wait_done(200, "busy_done");
        check_eq("busy_sample_cnt", d1_scnt, 32'd2);
        check_eq("busy_en_count", en_cyc_q.size(), 8);

        // Reset in the middle of a MAC sweep
        start1(11, 3, 11);
        nticks = 0;
        while (!(d1_we && !d1_zero) && nticks < 50) begin tick(); nticks++; end
        tick(); tick(); tick();
        check_eq("rst_in_mac_en", d1_en, 32'd1);
        rst_n = 1'b0;
        tick();
        check_all_zero("rst_mid_mac_outputs");
        rst_n = 1'b1;
        tick();
        start1(11, 1, 11);
        wait_done(200, "rst_rerun_done");
        if (wr_q.size() >= 1) check_eq("rst_rerun_wr_ptr0", wr_q[0], 32'h0);
        check_eq("rst_rerun_en_count", en_cyc_q.size(), 11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fir_addr_seq.md
# fir_addr_seq

Parametrised address sequencer and control FSM for the FIR engine. It zero-fills the data shift RAM, accepts one input sample per output and writes it into a circular buffer. It then sweeps tap and data RAM read addresses for a runtime-selectable tap count, aligns MAC enables to the RAM read latency, and holds each result under a valid/ready handshake until the programmed data length is reached. It sits between the AXI-Lite/AXI-Stream front end and the tap RAM, data RAM and MAC datapath.

## Interface
Parameters:
- pADDR_WIDTH, 12: byte-address width of the tap and data RAM ports.
- pMAX_TAPS, 32: data/tap RAM depth in words; power of two not required.
- pTAP_W, 6: width of tap_num; must hold pMAX_TAPS.
- pCNT_WIDTH, 10: width of data_len and sample_cnt.
- pRD_LAT, 1: RAM read latency in cycles (0..3); MAC strobes are delayed by this amount.
- pSTRIDE, 4: byte stride between words.

Ports:
- axis_clk  in  1  clock; all state updates on the rising edge.
- axis_rst_n  in  1  reset; asynchronous, active-low.
- ap_start  in  1  start pulse; sampled only in IDLE.
- tap_num  in  pTAP_W  taps N; latched at start; 0 clamps to 1, values above pMAX_TAPS clamp to pMAX_TAPS.
- data_len  in  pCNT_WIDTH  outputs L to produce; latched at start.
- ss_tvalid  in  1  input sample valid.
- ss_tready  out  1  sequencer ready for a sample.
- data_we  out  1  data RAM write enable.
- data_zero  out  1  write-data select: 1 = zero fill, 0 = stream sample.
- data_waddr  out  pADDR_WIDTH  data RAM write byte address.
- tap_raddr  out  pADDR_WIDTH  tap RAM read byte address.
- data_raddr  out  pADDR_WIDTH  data RAM read byte address.
- mac_clr  out  1  clear accumulator.
- mac_en  out  1  accumulate; aligned to read data.
- mac_last  out  1  final accumulate of the current output.
- result_valid  out  1  accumulator holds a finished output.
- result_ready  in  1  downstream accepts the result.
- sample_cnt  out  pCNT_WIDTH  outputs accepted since start.
- busy  out  1  high in every state other than IDLE and DONE.
- done  out  1  held high in DONE until the next ap_start.

## Operation
- The FSM has seven states: IDLE, INIT, WAIT_IN, WRITE, MAC, DRAIN, OUT. A separate DONE state is entered after the last output.
- IDLE: on ap_start, latch the clamped N and L, clear sample_cnt and wr_ptr, clear done, and go to INIT.
- INIT: runs for N cycles with data_we=1 and data_zero=1; data_waddr = j*pSTRIDE for j = 0..N-1. After INIT:
  - if L == 0, go to DONE;
  - otherwise go to WAIT_IN.
- WAIT_IN: ss_tready=1 and mac_clr=1. On ss_tvalid go to WRITE.
- WRITE: one cycle with data_we=1, data_zero=0, data_waddr = wr_ptr*pSTRIDE. Go to MAC.
- MAC: runs for N cycles, k = 0..N-1:
  - tap_raddr = k*pSTRIDE;
  - data_raddr = ((wr_ptr − k) mod N)*pSTRIDE;
  - an internal strobe is raised, with a last flag on k = N−1.
- DRAIN: pRD_LAT cycles. This state is skipped when pRD_LAT = 0.
- mac_en and mac_last are the internal strobe and last flag delayed by pRD_LAT cycles through a shift register.
- wr_ptr advances at the MAC→DRAIN/OUT transition, wrapping N−1 → 0.
- OUT: result_valid=1 is held while result_ready=0. On result_ready:
  - sample_cnt increments;
  - if the new count equals L, go to DONE, otherwise go to WAIT_IN.
- DONE: done=1, busy=0. On ap_start, behave as in IDLE.
- ap_start is ignored while busy.
- Arithmetic: the circular index is computed mod N on the latched N with no overflow. Addresses are zero-extended to pADDR_WIDTH. sample_cnt wraps only past 2^pCNT_WIDTH−1, which cannot occur because L fits the width.

## Timing
- All outputs are registered and are functions of state and counters only; there is no combinational input→output path.
- Reset: state=IDLE, every output 0, wr_ptr=0, sample_cnt=0, and the delay line is cleared.
  - Asserting reset mid-operation aborts immediately with no pending mac_en.
- Sample handshake: the transfer occurs in the cycle where ss_tvalid=1 and ss_tready=1. data_we for that sample is asserted on the next cycle.
- The first mac_en occurs 1 + pRD_LAT cycles after the WRITE cycle.
- mac_en is high for exactly N consecutive cycles, and mac_last coincides with the Nth.
- result_valid rises the cycle after the last mac_en.
- Per-output latency (handshake to result_valid) is 2 + N + pRD_LAT cycles. Minimum throughput is one output per N + pRD_LAT + 3 cycles.
- ss_tready stays 0 while result_valid=1, so no new sample is taken until the result is accepted.
- When ap_start and ss_tvalid arrive together in IDLE, the sample is not consumed; it is taken in WAIT_IN.

## Test plan
- Reset mid-MAC (N=11, pRD_LAT=1) → next cycle all outputs 0, IDLE; a subsequent ap_start runs cleanly from wr_ptr=0.
- ap_start with N=11, L=3, ss_tvalid held 1, result_ready held 1 → INIT writes 0x000..0x028. The first sample is written at 0x000, the second at 0x004. For the second output, data_raddr runs 0x004, 0x000, 0x028, 0x024…0x008 and tap_raddr runs 0x000…0x028. done rises after sample_cnt=3.
- N=4 over 6 samples → data_waddr sequence 0x0, 0x4, 0x8, 0xC, 0x0, 0x4 (wrap at N).
- pRD_LAT=2, N=3 → mac_en is high in three cycles starting 3 cycles after WRITE; mac_last is on the third; result_valid follows on the next cycle.
- result_ready held 0 for 5 cycles → result_valid stays 1, ss_tready stays 0, sample_cnt is unchanged; it increments on the cycle ready=1.
- Clamp cases:
  - tap_num=0 → single-tap sweep;
  - tap_num=40 with pMAX_TAPS=32 → INIT runs exactly 32 cycles;
  - L=0 → DONE directly after INIT;
  - ap_start during busy → ignored.
